// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel mux/demux pair: channel count, slot width,
// alignment FSM encoding and the slot-to-channel decode.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One-hot channel select for a slot number
  function automatic logic [NUM_CH-1:0] ch_onehot(input slot_t s);
    logic [NUM_CH-1:0] one_v;
    one_v = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one_v << s;
  endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// Bundle of the TDM receive stream and the four demultiplexed channel outputs.
// master drives the link side, slave is the demultiplexer.
interface tdm_demux_1to4_if #(
  parameter int W = 8
);

  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] out0;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] out3;
  logic [3:0]   out_valid;
  logic         frame_done;
  logic         locked;
  logic         sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  out0, out1, out2, out3, out_valid, frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output out0, out1, out2, out3, out_valid, frame_done, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Wrapping 2-bit TDM slot counter, shared by the transmit sequencer and receive demux.
// Priority: clr, then load1, then inc.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot,
  output logic  is_last
);

  slot_t slot_r;

  // Slot register; 3 -> 0 wrap comes from the natural 2-bit rollover
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r <= 2'd0;
    end else if (clr) begin
      slot_r <= 2'd0;
    end else if (load1) begin
      slot_r <= 2'd1;
    end else if (inc) begin
      slot_r <= slot_r + 2'd1;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign slot    = slot_r;
  assign is_last = (slot_r == 2'd3);

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer: steers each slot word to a registered channel output and
// tracks frame alignment with a HUNT/LOCKED FSM, flagging sync faults.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int W           = 8,
  parameter bit STRICT_SYNC = 1'b1
) (
  input logic             clk,
  input logic             rst,
  tdm_demux_1to4_if.slave bus
);

  state_t              state_r;
  state_t              next_state_s;
  slot_t               slot_s;
  logic                is_last_s;
  logic                clr_s;
  logic                load1_s;
  logic                inc_s;
  logic                wr_en_s;
  slot_t               wr_ch_s;
  logic [NUM_CH-1:0]   wr_onehot_s;
  logic                err_s;
  logic                done_s;
  logic [W-1:0]        out_r [NUM_CH];
  logic [NUM_CH-1:0]   out_valid_r;
  logic                frame_done_r;
  logic                sync_err_r;

  tdm_slot_counter u_slot (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .load1   (load1_s),
    .inc     (inc_s),
    .slot    (slot_s),
    .is_last (is_last_s)
  );

  // Alignment FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, slot control and write decode; a sync word always lands in channel 0
  always_comb begin
    next_state_s = state_r;
    clr_s        = 1'b0;
    load1_s      = 1'b0;
    inc_s        = 1'b0;
    wr_en_s      = 1'b0;
    wr_ch_s      = slot_s;
    err_s        = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      HUNT: begin
        if (bus.din_valid && bus.frame_sync) begin
          wr_en_s      = 1'b1;
          wr_ch_s      = 2'd0;
          load1_s      = 1'b1;
          next_state_s = LOCKED;
        end else begin
          next_state_s = HUNT;
        end
      end
      LOCKED: begin
        if (!bus.din_valid) begin
          next_state_s = LOCKED;
        end else if (bus.frame_sync) begin
          // Early sync abandons the partial frame and realigns on this word
          wr_en_s = 1'b1;
          wr_ch_s = 2'd0;
          load1_s = 1'b1;
          err_s   = (slot_s != 2'd0);
        end else if (slot_s == 2'd0) begin
          if (STRICT_SYNC == 1'b1) begin
            err_s        = 1'b1;
            clr_s        = 1'b1;
            next_state_s = HUNT;
          end else begin
            wr_en_s = 1'b1;
            inc_s   = 1'b1;
          end
        end else begin
          wr_en_s = 1'b1;
          inc_s   = 1'b1;
          done_s  = is_last_s;
        end
      end
      default: begin
        next_state_s = HUNT;
        clr_s        = 1'b1;
      end
    endcase
  end

  assign wr_onehot_s = wr_en_s ? ch_onehot(wr_ch_s) : {NUM_CH{1'b0}};

  // Channel holding registers; unwritten channels keep stale data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        out_r[k] <= {W{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_onehot_s[k]) begin
          out_r[k] <= bus.din;
        end else begin
          out_r[k] <= out_r[k];
        end
      end
    end
  end

  // One-cycle strobe and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= {NUM_CH{1'b0}};
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      out_valid_r  <= wr_onehot_s;
      frame_done_r <= done_s;
      sync_err_r   <= err_s;
    end
  end

  assign bus.out0       = out_r[0];
  assign bus.out1       = out_r[1];
  assign bus.out2       = out_r[2];
  assign bus.out3       = out_r[3];
  assign bus.out_valid  = out_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.sync_err   = sync_err_r;
  assign bus.locked     = (state_r == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: directed vector table, a strict/non-strict corner sequence
// and randomized traffic against a frame-level reference model, on both sync modes.
module tb_tdm_demux_1to4;

  typedef struct {
    logic       rst;
    logic       dv;
    logic       fs;
    logic [7:0] din;
    logic [3:0] ov;
    logic       fd;
    logic       lk;
    logic       se;
    int         ch;
    logic [7:0] dat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  // Reference model state, index 0 = non-strict DUT, 1 = strict DUT
  logic       m_lk  [2];
  int         m_pos [2];
  logic [7:0] m_out [2][4];
  logic [3:0] e_ov  [2];
  logic       e_fd  [2];
  logic       e_se  [2];

  tdm_demux_1to4_if #(.W(8)) bus0 ();
  tdm_demux_1to4_if #(.W(8)) bus1 ();

  tdm_demux_1to4 #(.W(8), .STRICT_SYNC(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tdm_demux_1to4 #(.W(8), .STRICT_SYNC(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, dv, fs, input logic [7:0] d, input logic [3:0] ov,
                              input logic fd, lk, se, input int ch, input logic [7:0] dat);
    vec_t v;
    v.rst = r; v.dv = dv; v.fs = fs; v.din = d; v.ov = ov;
    v.fd = fd; v.lk = lk; v.se = se; v.ch = ch; v.dat = dat;
    return v;
  endfunction

  function automatic logic [63:0] snap0();
    return {25'd0, bus0.out3, bus0.out2, bus0.out1, bus0.out0,
            bus0.out_valid, bus0.frame_done, bus0.locked, bus0.sync_err};
  endfunction

  function automatic logic [63:0] snap1();
    return {25'd0, bus1.out3, bus1.out2, bus1.out1, bus1.out0,
            bus1.out_valid, bus1.frame_done, bus1.locked, bus1.sync_err};
  endfunction

  function automatic logic [63:0] model_snap(input int i);
    return {25'd0, m_out[i][3], m_out[i][2], m_out[i][1], m_out[i][0],
            e_ov[i], e_fd[i], m_lk[i], e_se[i]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic dv, input logic fs, input logic [7:0] d);
    rst            = r;
    bus0.din       = d;
    bus0.din_valid = dv;
    bus0.frame_sync = fs;
    bus1.din       = d;
    bus1.din_valid = dv;
    bus1.frame_sync = fs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level rules: a sync word opens a frame at channel 0, later words fill
  // channels in arrival order, an unsynced word where a frame should start is a fault.
  task automatic model_step(input int i, input bit strict, input logic r, input logic dv,
                            input logic fs, input logic [7:0] d);
    e_ov[i] = 4'b0000;
    e_fd[i] = 1'b0;
    e_se[i] = 1'b0;
    if (r) begin
      m_lk[i]  = 1'b0;
      m_pos[i] = 0;
      for (int c = 0; c < 4; c++) m_out[i][c] = 8'h00;
    end else if (dv) begin
      if (fs) begin
        e_se[i]     = m_lk[i] && (m_pos[i] != 0);
        m_out[i][0] = d;
        e_ov[i]     = 4'b0001;
        m_pos[i]    = 1;
        m_lk[i]     = 1'b1;
      end else if (m_lk[i]) begin
        if (m_pos[i] == 0 && strict) begin
          e_se[i] = 1'b1;
          m_lk[i] = 1'b0;
        end else begin
          m_out[i][m_pos[i]] = d;
          e_ov[i]  = 4'(1 << m_pos[i]);
          e_fd[i]  = (m_pos[i] == 3);
          m_pos[i] = (m_pos[i] + 1) % 4;
        end
      end
    end
  endtask

  initial begin
    logic [63:0] s0;
    logic [63:0] s1;
    logic        r;
    logic        dv;
    logic        fs;
    logic [7:0]  d;

    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // Clean frame from reset
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hA0, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 8'hA0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA1, 4'b0010, 1'b0, 1'b1, 1'b0, 1, 8'hA1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA2, 4'b0100, 1'b0, 1'b1, 1'b0, 2, 8'hA2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA3, 4'b1000, 1'b1, 1'b1, 1'b0, 3, 8'hA3));
    // HUNT drops unsynced words
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 3, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h11, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h22, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h33, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 8'h33));
    // Early sync realigns
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h01, 4'b0010, 1'b0, 1'b1, 1'b0, 1, 8'h01));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h5A, 4'b0001, 1'b0, 1'b1, 1'b1, 0, 8'h5A));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h02, 4'b0010, 1'b0, 1'b1, 1'b0, 1, 8'h02));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h03, 4'b0100, 1'b0, 1'b1, 1'b0, 2, 8'h03));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h04, 4'b1000, 1'b1, 1'b1, 1'b0, 3, 8'h04));
    // Frame with idle gaps; frame_sync on idle cycles must be ignored
    for (int s = 0; s < 4; s++) begin
      tbl.push_back(mk(1'b0, 1'b1, (s == 0), 8'hB0 + 8'(s), 4'(1 << s), (s == 3), 1'b1, 1'b0,
                       s, 8'hB0 + 8'(s)));
      if (s != 3) begin
        for (int g = 0; g < 3; g++) begin
          tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hEE, 4'b0000, 1'b0, 1'b1, 1'b0, s, 8'hB0 + 8'(s)));
        end
      end
    end
    // Reset mid-frame loses the in-flight word, then hunt again
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hC0, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 8'hC0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC1, 4'b0010, 1'b0, 1'b1, 1'b0, 1, 8'hC1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC2, 4'b0100, 1'b0, 1'b1, 1'b0, 2, 8'hC2));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'hC3, 4'b0000, 1'b0, 1'b0, 1'b0, 2, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hD0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hD1, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hD2, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 8'hD2));
    // Strict mode: missing sync at slot 0 drops the word and unlocks
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hD3, 4'b0010, 1'b0, 1'b1, 1'b0, 1, 8'hD3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hD4, 4'b0100, 1'b0, 1'b1, 1'b0, 2, 8'hD4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hD5, 4'b1000, 1'b1, 1'b1, 1'b0, 3, 8'hD5));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h77, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 8'hD2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h78, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 8'hD2));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].dv, tbl[i].fs, tbl[i].din);
      step();
      s1 = snap1();
      chk($sformatf("tbl%0d_status", i), 64'(s1[6:0]),
          64'({tbl[i].ov, tbl[i].fd, tbl[i].lk, tbl[i].se}));
      chk($sformatf("tbl%0d_out%0d", i, tbl[i].ch), 64'(s1[7 + 8*tbl[i].ch +: 8]),
          64'(tbl[i].dat));
    end

    // Same unsynced slot-0 word on both sync modes
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 1'b1, (s == 0), 8'hE0 + 8'(s));
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 8'h77);
    step();
    s0 = snap0();
    s1 = snap1();
    chk("loose_status", 64'(s0[6:0]), 64'({4'b0001, 1'b0, 1'b1, 1'b0}));
    chk("loose_out0", 64'(s0[14:7]), 64'h77);
    chk("strict_status", 64'(s1[6:0]), 64'({4'b0000, 1'b0, 1'b0, 1'b1}));
    chk("strict_out0", 64'(s1[14:7]), 64'hE0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      r  = (n == 0) || ($urandom_range(0, 59) == 0);
      dv = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 5) == 0);
      d  = 8'($urandom);
      drive(r, dv, fs, d);
      model_step(0, 1'b0, r, dv, fs, d);
      model_step(1, 1'b1, r, dv, fs, d);
      step();
      chk($sformatf("rnd%0d_loose", n), snap0(), model_snap(0));
      chk($sformatf("rnd%0d_strict", n), snap1(), model_snap(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
